// File: rtl/game_fsm.sv
// Reaction game controller: start/hit edge detection, five-state game FSM,
// score keeping, and the WIN/LOSE hold timer with LED blink.
module game_fsm #(
   parameter int TARGET = 10,
   parameter int HOLD   = 8
) (
   input  logic       clk_4_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic       hit_i,
   input  logic [4:0] count_i,
   output logic       count_en_o,
   output logic       count_rst_no,
   output logic [3:0] score_o,
   output logic       win_o,
   output logic       lose_o,
   output logic       flash_o
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_PLAY = 3'd2;
   localparam logic [2:0] S_WIN  = 3'd3;
   localparam logic [2:0] S_LOSE = 3'd4;

   localparam logic [3:0] TGT       = 4'(TARGET);
   localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

   logic [2:0] state, state_nxt;
   logic [3:0] score, score_nxt;
   logic [7:0] hold_cnt, hold_nxt;
   logic       start_q, hit_q;
   logic       start_press, hit_press, count_zero, in_end;
   logic [3:0] score_inc;

   assign start_press = start_i & ~start_q;
   assign hit_press   = hit_i & ~hit_q;
   assign count_zero  = (count_i == 5'd0);
   assign score_inc   = score + 4'd1;
   assign in_end      = (state == S_WIN) || (state == S_LOSE);

   always_comb begin
      state_nxt = state;
      score_nxt = score;
      hold_nxt  = hold_cnt;
      case (state)
         S_IDLE: begin
            if (start_press) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            score_nxt = 4'd0;
            state_nxt = S_PLAY;
         end
         S_PLAY: begin
            // Every exit from PLAY lands in WIN/LOSE, so the timer is cleared here.
            hold_nxt = 8'd0;
            if (hit_press) score_nxt = score_inc;
            if (hit_press && (score_inc == TGT)) state_nxt = S_WIN;
            else if (count_zero)                 state_nxt = S_LOSE;
         end
         S_WIN, S_LOSE: begin
            if (start_press)                 state_nxt = S_LOAD;
            else if (hold_cnt == HOLD_LAST)  state_nxt = S_IDLE;
            else                             hold_nxt  = hold_cnt + 8'd1;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_4_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= S_IDLE;
         score    <= 4'd0;
         hold_cnt <= 8'd0;
         start_q  <= 1'b0;
         hit_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         score    <= score_nxt;
         hold_cnt <= hold_nxt;
         start_q  <= start_i;
         hit_q    <= hit_i;
      end
   end

   // count_en_o stays combinational on count_i so the counter stops exactly at 0.
   assign count_en_o   = (state == S_PLAY) && !count_zero;
   assign count_rst_no = (state != S_LOAD);
   assign score_o      = score;
   assign win_o        = (state == S_WIN);
   assign lose_o       = (state == S_LOSE);
   assign flash_o      = in_end && !hold_cnt[1];

endmodule

// File: tb/tb_game_fsm.sv
// Directed bench for game_fsm: per-cycle vector table plus hand-written
// sequences for reset release with held buttons and asynchronous reset.
module tb_game_fsm;

   logic       clk_4_i = 1'b0;
   logic       rst_i   = 1'b1;
   logic       start_i = 1'b0;
   logic       hit_i   = 1'b0;
   logic [4:0] count_i = 5'd31;
   logic       count_en_o, count_rst_no, win_o, lose_o, flash_o;
   logic [3:0] score_o;

   int pass_cnt = 0;
   int total    = 0;

   game_fsm #(.TARGET(10), .HOLD(8)) dut (
      .clk_4_i      (clk_4_i),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .hit_i        (hit_i),
      .count_i      (count_i),
      .count_en_o   (count_en_o),
      .count_rst_no (count_rst_no),
      .score_o      (score_o),
      .win_o        (win_o),
      .lose_o       (lose_o),
      .flash_o      (flash_o)
   );

   always #5 clk_4_i = ~clk_4_i;

   // Expected word layout: {count_en, count_rst_n, score[3:0], win, lose, flash}
   typedef struct {
      string      nm;
      bit         rst, st, hit;
      logic [4:0] cnt;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string nm, input bit rst, input bit st, input bit hit,
                      input logic [4:0] cnt, input bit en, input bit rn,
                      input logic [3:0] sc, input bit w, input bit l, input bit f);
      vec_t v;
      v.nm  = nm;
      v.rst = rst;
      v.st  = st;
      v.hit = hit;
      v.cnt = cnt;
      v.exp = {en, rn, sc, w, l, f};
      vecs.push_back(v);
   endtask

   function automatic logic [8:0] outs();
      return {count_en_o, count_rst_no, score_o, win_o, lose_o, flash_o};
   endfunction

   task automatic check(input string nm, input logic [8:0] exp);
      logic [8:0] act;
      act = outs();
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got en/rn/score/win/lose/flash=%b want %b", nm, act, exp);
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Game 1: start, ten hit pulses, full WIN hold, IDLE ignores hit.
      add("rst",        1, 0, 0, 31, 0, 1, 0, 0, 0, 0);
      add("idle",       0, 0, 0, 31, 0, 1, 0, 0, 0, 0);
      add("idle_start", 0, 1, 0, 31, 0, 1, 0, 0, 0, 0);
      add("load",       0, 0, 0, 31, 0, 0, 0, 0, 0, 0);
      add("play0",      0, 0, 0, 31, 1, 1, 0, 0, 0, 0);
      for (int k = 0; k < 9; k++) begin
         add("a_hit", 0, 0, 1, 5'(30 - 2*k), 1, 1, 4'(k),     0, 0, 0);
         add("a_gap", 0, 0, 0, 5'(29 - 2*k), 1, 1, 4'(k + 1), 0, 0, 0);
      end
      add("a_hit10",    0, 0, 1, 12, 1, 1, 9, 0, 0, 0);
      for (int j = 0; j < 8; j++)
         add("a_win",   0, 0, 0, 12, 0, 1, 10, 1, 0, bit'((j % 4) < 2));
      add("a_idle",     0, 0, 0, 12, 0, 1, 10, 0, 0, 0);
      add("idle_hit",   0, 0, 1, 12, 0, 1, 10, 0, 0, 0);
      add("idle_hold",  0, 0, 0, 12, 0, 1, 10, 0, 0, 0);

      // Game 2: held hit counts once, countdown to 0, full LOSE hold.
      add("b_start",    0, 1, 0, 3, 0, 1, 10, 0, 0, 0);
      add("b_load",     0, 0, 0, 3, 0, 0, 10, 0, 0, 0);
      add("b_play",     0, 0, 0, 3, 1, 1, 0, 0, 0, 0);
      add("b_held",     0, 0, 1, 3, 1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++)
         add("b_held",  0, 0, 1, 3, 1, 1, 1, 0, 0, 0);
      add("b_rel",      0, 0, 0, 2, 1, 1, 1, 0, 0, 0);
      add("b_c1",       0, 0, 0, 1, 1, 1, 1, 0, 0, 0);
      add("b_c0",       0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      for (int j = 0; j < 8; j++)
         add("b_lose",  0, 0, 0, 0, 0, 1, 1, 0, 1, bit'((j % 4) < 2));
      add("b_idle",     0, 0, 0, 0, 0, 1, 1, 0, 0, 0);

      // Game 3: hit on count 0 at score 9 wins, start overrides hold timer.
      add("c_start",    0, 1, 0, 20, 0, 1, 1, 0, 0, 0);
      add("c_load",     0, 0, 0, 20, 0, 0, 1, 0, 0, 0);
      for (int k = 0; k < 9; k++) begin
         add("c_hit", 0, 0, 1, 20, 1, 1, 4'(k),     0, 0, 0);
         add("c_gap", 0, 0, 0, 20, 1, 1, 4'(k + 1), 0, 0, 0);
      end
      add("c_hit9_c0",  0, 0, 1, 0, 0, 1, 9, 0, 0, 0);
      add("c_win",      0, 0, 0, 0, 0, 1, 10, 1, 0, 1);
      add("c_win",      0, 0, 0, 0, 0, 1, 10, 1, 0, 1);
      add("c_win_start",0, 1, 0, 0, 0, 1, 10, 1, 0, 0);
      add("c_load2",    0, 0, 0, 20, 0, 0, 10, 0, 0, 0);
      // Game 4: hit on count 0 at score 5 loses with score 6.
      for (int k = 0; k < 5; k++) begin
         add("d_hit", 0, 0, 1, 20, 1, 1, 4'(k),     0, 0, 0);
         add("d_gap", 0, 0, 0, 20, 1, 1, 4'(k + 1), 0, 0, 0);
      end
      add("d_hit5_c0",  0, 0, 1, 0, 0, 1, 5, 0, 0, 0);
      add("d_lose",     0, 0, 0, 0, 0, 1, 6, 0, 1, 1);
      add("d_lose_st",  0, 1, 0, 0, 0, 1, 6, 0, 1, 1);
      add("d_load",     0, 0, 0, 20, 0, 0, 6, 0, 0, 0);
      // Game 5: win, then asynchronous reset mid-WIN.
      for (int k = 0; k < 9; k++) begin
         add("e_hit", 0, 0, 1, 20, 1, 1, 4'(k),     0, 0, 0);
         add("e_gap", 0, 0, 0, 20, 1, 1, 4'(k + 1), 0, 0, 0);
      end
      add("e_hit10",    0, 0, 1, 20, 1, 1, 9, 0, 0, 0);
      add("e_win",      0, 0, 0, 20, 0, 1, 10, 1, 0, 1);
      add("e_win",      0, 0, 0, 20, 0, 1, 10, 1, 0, 1);
      add("e_rst",      1, 0, 0, 20, 0, 1, 0, 0, 0, 0);
      add("e_post",     0, 0, 0, 20, 0, 1, 0, 0, 0, 0);

      // Inputs change after the falling edge; outputs sampled 1 time unit later.
      foreach (vecs[i]) begin
         @(negedge clk_4_i);
         rst_i   = vecs[i].rst;
         start_i = vecs[i].st;
         hit_i   = vecs[i].hit;
         count_i = vecs[i].cnt;
         #1;
         check(vecs[i].nm, vecs[i].exp);
      end

      // Buttons held through reset release register a press right after release.
      @(negedge clk_4_i);
      rst_i = 1'b1; start_i = 1'b1; hit_i = 1'b1; count_i = 5'd20;
      #1 check("h_rst_held", 9'b0_1_0000_000);
      @(negedge clk_4_i);
      rst_i = 1'b0;
      #1 check("h_release_idle", 9'b0_1_0000_000);
      @(negedge clk_4_i);
      #1 check("h_load_from_held", 9'b0_0_0000_000);
      @(negedge clk_4_i);
      #1 check("h_play_held_hit", 9'b1_1_0000_000);
      @(negedge clk_4_i);
      #1 check("h_play_no_press", 9'b1_1_0000_000);
      hit_i = 1'b0;
      @(negedge clk_4_i);
      hit_i = 1'b1;
      @(negedge clk_4_i);
      hit_i = 1'b0;
      #1 check("h_score1", 9'b1_1_0001_000);

      // Reset mid-PLAY, asserted during the high clock phase.
      @(posedge clk_4_i);
      #2 rst_i = 1'b1;
      #1 check("h_async_play", 9'b0_1_0000_000);
      @(negedge clk_4_i);
      rst_i = 1'b0; start_i = 1'b0;
      #1 check("h_after_rst", 9'b0_1_0000_000);
      @(negedge clk_4_i);
      start_i = 1'b1;
      @(negedge clk_4_i);
      start_i = 1'b0;
      #1 check("h_reload", 9'b0_0_0000_000);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/game_fsm.md
GAME_FSM -- requirements
Module: game_fsm

Interface
REQ-001 Parameter: TARGET, 10, hits needed to win; legal range 1-15.
REQ-002 Parameter: HOLD, 8, clk_4_i cycles spent in WIN or LOSE before auto-return to IDLE; legal range 2-255.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk_4_i  input  1  4 Hz game clock, all state on rising edge.
REQ-005 rst_i  input  1  asynchronous active-high reset.
REQ-006 start_i  input  1  start button level, synchronous to clk_4_i.
REQ-007 hit_i  input  1  hit button level, synchronous to clk_4_i.
REQ-008 count_i  input  5  current countdown value from the downstream game counter.
REQ-009 count_en_o  output  1  decrement enable to the game counter.
REQ-010 count_rst_no  output  1  active-low synchronous reload request to the game counter; reload value is 31.
REQ-011 score_o  output  4  hits scored in the current game.
REQ-012 win_o, lose_o  output  1 each  high while in WIN or LOSE respectively.
REQ-013 flash_o  output  1  LED blink during WIN or LOSE.

Function
REQ-014 The block SHALL register start_i and hit_i each cycle; a press SHALL be a rising edge: current level 1, registered level 0.
REQ-015 The FSM SHALL have states IDLE, LOAD, PLAY, WIN, LOSE.
REQ-016 IDLE: start press -> LOAD; hit ignored; score_o holds its last value.
REQ-017 LOAD: lasts exactly one cycle; count_rst_no=0; score cleared to 0 on exit; always -> PLAY.
REQ-018 count_rst_no SHALL be 0 only in LOAD, 1 in every other state.
REQ-019 PLAY: count_en_o SHALL be 1 when count_i!=0, else 0, combinationally, so the counter halts at 0 and does not wrap.
REQ-020 PLAY: hit press SHALL increment score_o by 1; if the new score equals TARGET -> WIN on the same edge.
REQ-021 PLAY: count_i==0 with no hit press -> LOSE.
REQ-022 PLAY: hit press and count_i==0 in the same cycle SHALL count the hit first. If the new score equals TARGET -> WIN, else -> LOSE.
REQ-023 PLAY: start press SHALL be ignored.
REQ-024 score_o SHALL never exceed TARGET and SHALL change only in LOAD exit or PLAY.
REQ-025 WIN/LOSE: an 8-bit hold counter SHALL clear on entry and increment each cycle. When it reaches HOLD-1 the FSM -> IDLE on the next edge, giving exactly HOLD cycles in the state.
REQ-026 WIN/LOSE: start press -> LOAD immediately, overriding the hold timer.
REQ-027 flash_o SHALL be 1 on the first cycle of WIN/LOSE and toggle every 2 cycles (1,1,0,0,...); it SHALL be 0 in all other states.
REQ-028 count_en_o SHALL be 0 in all states except PLAY.
REQ-029 All outputs except count_en_o SHALL be registered or decoded from registered state only.

Reset
REQ-030 rst_i high SHALL immediately force: state IDLE, score 0, hold counter 0, edge registers 0.
REQ-031 While in reset, outputs SHALL be: count_en_o=0, count_rst_no=1, win_o=0, lose_o=0, flash_o=0.
REQ-032 Reset asserted mid-PLAY SHALL abandon the game. The count_i value is left unchanged; the next start press reloads it via LOAD.
REQ-033 Buttons held high through reset release SHALL register a press on the first cycle after release, since the edge registers reset to 0.

Verification
REQ-034 Reset, start pulse 1 cycle -> one LOAD cycle with count_rst_no=0, then PLAY with count_en_o=1, score_o=0.
REQ-035 PLAY, 10 single-cycle hit presses before count_i reaches 0 -> score_o steps 1..10, win_o=1 on the edge of the 10th hit.
REQ-036 PLAY, no hits, count_i reaches 0 -> count_en_o=0 while count_i=0, lose_o=1 next cycle.
REQ-037 hit_i held high 5 cycles in PLAY -> score_o increments by exactly 1.
REQ-038 score_o=9, hit press in the cycle count_i=0 -> WIN, score_o=10. Repeat with score_o=5 -> LOSE, score_o=6.
REQ-039 WIN with HOLD=8 -> flash_o pattern 1,1,0,0,1,1,0,0, then IDLE. Repeat with a start press at hold cycle 3 -> LOAD next cycle. Repeat with rst_i pulsed mid-WIN -> IDLE asynchronously, all outputs at reset values.
